// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - IF stage: PC, IF/ID register, stall/redirect handling, HALT parking (optional FETCH_CNT_EN fetch counter)
module instr_fetch #(
    parameter int                ADDR_W   = 8,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              stall,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] branch_target,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [15:0]       imem_rdata,
    output logic [15:0]       if_instr,
    output logic [ADDR_W-1:0] if_pc,
    output logic              if_valid,
    output logic              halted
`ifdef FETCH_CNT_EN
    ,
    output logic [15:0]       fetch_cnt
`endif
);

    localparam logic [4:0]  OP_HALT = 5'b00001;
    localparam logic [15:0] NOP     = 16'h0000;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_HALTED
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] pc;
    logic              rdata_is_halt;

    // The memory is read combinationally, so the PC itself is the fetch address.
    assign imem_addr     = pc;
    assign rdata_is_halt = (imem_rdata[15:11] == OP_HALT);

    // Front-end state machine: owns PC, the IF/ID register and the halted flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            pc       <= RESET_PC;
            if_instr <= NOP;
            if_pc    <= '0;
            if_valid <= 1'b0;
            halted   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    // Nothing is fetched until start; the first real latch
                    // happens on the edge after the one that enters RUN.
                    if_instr <= NOP;
                    if_valid <= 1'b0;
                    if (start) begin
                        state <= S_RUN;
                    end
                end

                S_RUN: begin
                    if (branch_taken) begin
                        // The word at pc is on the wrong path; drop it and
                        // restart at the target. A redirect beats any stall.
                        pc       <= branch_target;
                        if_instr <= NOP;
                        if_valid <= 1'b0;
                    end else if (!stall) begin
                        if_instr <= imem_rdata;
                        if_pc    <= pc;
                        if_valid <= 1'b1;
                        if (rdata_is_halt) begin
                            // Park on the HALT address so a later redirect
                            // is the only way out.
                            state  <= S_HALTED;
                            halted <= 1'b1;
                        end else begin
                            pc <= pc + ADDR_W'(1);
                        end
                    end
                end

                S_HALTED: begin
                    if (branch_taken) begin
                        // An older branch resolved taken: the HALT was
                        // fetched speculatively and must be abandoned.
                        pc       <= branch_target;
                        if_instr <= NOP;
                        if_valid <= 1'b0;
                        halted   <= 1'b0;
                        state    <= S_RUN;
                    end else if (!stall) begin
                        // Once decode has taken the HALT word, feed bubbles.
                        if_instr <= NOP;
                        if_valid <= 1'b0;
                    end
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef FETCH_CNT_EN
    logic fetch_latch;

    // A real instruction enters IF/ID only on an unstalled, unredirected RUN cycle.
    assign fetch_latch = (state == S_RUN) && !branch_taken && !stall;

    // Saturating count of valid latches; flushes do not take anything back.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_cnt <= 16'h0000;
        end else if (fetch_latch && (fetch_cnt != 16'hFFFF)) begin
            fetch_cnt <= fetch_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - scoreboard bench for instr_fetch
module tb_instr_fetch;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        stall;
    logic        branch_taken;
    logic [7:0]  branch_target;
    logic [7:0]  imem_addr;
    logic [15:0] imem_rdata;
    logic [15:0] if_instr;
    logic [7:0]  if_pc;
    logic        if_valid;
    logic        halted;
`ifdef FETCH_CNT_EN
    logic [15:0] fetch_cnt;
`endif

    logic [15:0] mem [256];

    int n_tests = 0;
    int n_fail  = 0;

    // expected IF/ID latches: {pc, word}
    logic [23:0] sb_q [$];

    // reference model
    int          m_state;
    logic [7:0]  m_pc;
    logic [7:0]  m_ifpc;
    logic [15:0] m_instr;
    logic        m_valid;
    logic        m_halted;
    logic [15:0] m_cnt;

    instr_fetch #(.ADDR_W(8), .RESET_PC(8'h00)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .imem_addr     (imem_addr),
        .imem_rdata    (imem_rdata),
        .if_instr      (if_instr),
        .if_pc         (if_pc),
        .if_valid      (if_valid),
        .halted        (halted)
`ifdef FETCH_CNT_EN
        ,
        .fetch_cnt     (fetch_cnt)
`endif
    );

    assign imem_rdata = mem[imem_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_state  = 0;
        m_pc     = 8'h00;
        m_ifpc   = 8'h00;
        m_instr  = 16'h0000;
        m_valid  = 1'b0;
        m_halted = 1'b0;
        m_cnt    = 16'h0000;
        sb_q.delete();
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_addr"},  32'(imem_addr), 32'h00);
        check({tag, "_instr"}, 32'(if_instr),  32'h0000);
        check({tag, "_ifpc"},  32'(if_pc),     32'h00);
        check({tag, "_valid"}, 32'(if_valid),  32'h0);
        check({tag, "_halt"},  32'(halted),    32'h0);
`ifdef FETCH_CNT_EN
        check({tag, "_cnt"},   32'(fetch_cnt), 32'h0);
`endif
    endtask

    // One clock: drive inputs, advance the model, compare just after the edge.
    task automatic step(input logic st, input logic sl, input logic br, input logic [7:0] tgt);
        logic [15:0] w;
        logic [23:0] e;
        bit          latched;
        latched       = 0;
        start         = st;
        stall         = sl;
        branch_taken  = br;
        branch_target = tgt;
        case (m_state)
            0: if (st) m_state = 1;
            1: begin
                if (br) begin
                    m_pc    = tgt;
                    m_valid = 1'b0;
                    m_instr = 16'h0000;
                end else if (!sl) begin
                    w = mem[m_pc];
                    sb_q.push_back({m_pc, w});
                    latched = 1;
                    m_instr = w;
                    m_ifpc  = m_pc;
                    m_valid = 1'b1;
                    if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
                    if (w[15:11] == 5'b00001) begin
                        m_state  = 2;
                        m_halted = 1'b1;
                    end else begin
                        m_pc = m_pc + 8'd1;
                    end
                end
            end
            default: begin
                if (br) begin
                    m_pc     = tgt;
                    m_halted = 1'b0;
                    m_state  = 1;
                    m_valid  = 1'b0;
                    m_instr  = 16'h0000;
                end else if (!sl) begin
                    m_valid = 1'b0;
                    m_instr = 16'h0000;
                end
            end
        endcase
        @(posedge clk);
        #1;
        check("addr",   32'(imem_addr), 32'(m_pc));
        check("valid",  32'(if_valid),  32'(m_valid));
        check("instr",  32'(if_instr),  32'(m_instr));
        check("halted", 32'(halted),    32'(m_halted));
        if (m_valid) check("ifpc", 32'(if_pc), 32'(m_ifpc));
        if (latched) begin
            e = sb_q.pop_front();
            check("sb_pc",    32'(if_pc),    32'(e[23:16]));
            check("sb_instr", 32'(if_instr), 32'(e[15:0]));
        end
`ifdef FETCH_CNT_EN
        check("cnt", 32'(fetch_cnt), 32'(m_cnt));
`endif
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = {1'b1, 15'(i * 37)};
        mem[0] = 16'h4101;
        mem[1] = 16'h4902;
        mem[2] = 16'h0000;
        mem[7] = 16'h0800;

        rst_n         = 1'b0;
        start         = 1'b0;
        stall         = 1'b0;
        branch_taken  = 1'b0;
        branch_target = 8'h00;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_reset_values("rst");
        @(negedge clk);
        rst_n = 1'b1;

        // IDLE ignores stall and redirect
        step(0, 1, 1, 8'h33);
        check("idle_addr", 32'(imem_addr), 32'h00);
        step(1, 0, 0, 8'h00);
        check("start_nolatch", 32'(if_valid), 32'h0);

        step(0, 0, 0, 8'h00);
        check("first_pc", 32'(if_pc), 32'h00);
        check("first_instr", 32'(if_instr), 32'h4101);
        step(0, 0, 0, 8'h00);
        check("second_instr", 32'(if_instr), 32'h4902);

        for (int i = 0; i < 3; i++) begin
            step(0, 1, 0, 8'h00);
            check("stall_addr", 32'(imem_addr), 32'h02);
            check("stall_ifpc", 32'(if_pc), 32'h01);
        end
        step(0, 0, 0, 8'h00);
        check("resume_ifpc", 32'(if_pc), 32'h02);
        step(0, 0, 0, 8'h00);
        step(0, 0, 0, 8'h00);

        // redirect from pc=5 to 7, stall in same cycle is ignored
        check("pre_br_addr", 32'(imem_addr), 32'h05);
        step(0, 1, 1, 8'h07);
        check("flush_valid", 32'(if_valid), 32'h0);
        check("flush_instr", 32'(if_instr), 32'h0000);

        step(0, 0, 0, 8'h00);
        check("halt_ifpc", 32'(if_pc), 32'h07);
        check("halt_word", 32'(if_instr), 32'h0800);
        check("halt_flag", 32'(halted), 32'h1);

        // stall keeps the HALT word visible, then bubbles
        step(0, 1, 0, 8'h00);
        check("halt_hold", 32'(if_valid), 32'h1);
        for (int i = 0; i < 10; i++) begin
            step(1'(i), 0, 0, 8'h00);
            check("parked_addr", 32'(imem_addr), 32'h07);
            check("parked_valid", 32'(if_valid), 32'h0);
        end

        step(0, 1, 1, 8'h01);
        check("unhalt", 32'(halted), 32'h0);
        step(0, 0, 0, 8'h00);
        check("unhalt_ifpc", 32'(if_pc), 32'h01);

        // pc wrap 255 -> 0
        step(0, 0, 1, 8'hFE);
        step(0, 0, 0, 8'h00);
        step(0, 0, 0, 8'h00);
        check("wrap_addr", 32'(imem_addr), 32'h00);
        step(0, 0, 0, 8'h00);
        check("wrap_ifpc", 32'(if_pc), 32'h00);

        // asynchronous reset between edges
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_values("mid_rst");
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;

        // clean run 0..7 ending in HALT
        step(1, 0, 0, 8'h00);
        for (int i = 0; i < 20 && !halted; i++) step(0, 0, 0, 8'h00);
        check("halt_reach", 32'(halted), 32'h1);
        check("halt_run_pc", 32'(if_pc), 32'h07);
`ifdef FETCH_CNT_EN
        check("cnt_eight", 32'(fetch_cnt), 32'd8);
`endif

        check("sb_empty", 32'(sb_q.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- IF stage of the 16-bit pipeline CPU; drives the address of the synchronous-write/combinational-read instruction memory (8-bit address, 16-bit word) and consumes its data.
- Owns the PC, issues one fetch per cycle into the IF/ID register, honours decode stalls and EX-stage branch redirects.
- Detects HALT (opcode 5'b00001 in bits [15:11]) and parks the front end.

Parameters:
- ADDR_W, 8, PC / instruction-memory address width.
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  single-cycle pulse; leaves IDLE.
- stall  input  1  hazard stall from decode; freezes PC and IF/ID.
- branch_taken  input  1  redirect from EX (jump/branch resolved taken).
- branch_target  input  ADDR_W  redirect address.
- imem_addr  output  ADDR_W  instruction memory address (combinational = pc).
- imem_rdata  input  16  instruction word at imem_addr, same cycle.
- if_instr  output  16  IF/ID instruction register.
- if_pc  output  ADDR_W  address of if_instr.
- if_valid  output  1  if_instr is a real fetched instruction.
- halted  output  1  front end parked on HALT.

Behaviour:
- Reset (async, rst_n=0): pc=RESET_PC, state=IDLE, if_instr=16'h0000 (NOP), if_pc=0, if_valid=0, halted=0. Release is synchronous to next clk edge.
- imem_addr = pc at all times, no register.
- States: IDLE, RUN, HALTED.
- IDLE: if_valid=0, if_instr=NOP, pc held. start=1 -> RUN next cycle; first fetch (pc=RESET_PC) latched the cycle after. stall/branch_taken ignored.
- RUN, priority branch_taken > stall > normal:
  - branch_taken: pc<=branch_target; if_instr<=NOP, if_valid<=0 (flush wrong-path word); stall ignored same cycle.
  - stall (no branch): pc, if_instr, if_pc, if_valid all hold.
  - normal: if_instr<=imem_rdata, if_pc<=pc, if_valid<=1, pc<=pc+1 modulo 2^ADDR_W (255 -> 0 wrap, no flag).
  - normal and imem_rdata[15:11]==HALT: HALT word latched with if_valid=1, pc NOT incremented, state->HALTED, halted<=1.
- HALTED: if_valid=0 and if_instr=NOP from the cycle after the HALT word, unless stall holds IF/ID (HALT word stays visible while stall=1). pc frozen. start ignored. branch_taken -> pc<=branch_target, halted<=0, state->RUN (older branch in flight cancels speculatively fetched HALT).
- Latency: imem_rdata at pc in cycle N appears on if_instr in cycle N+1.
- Reset mid-operation: immediate return to reset values regardless of state.

Optional Feature:
- Macro FETCH_CNT_EN. Defined: extra output fetch_cnt (16 bits), reset 0, +1 on every edge where a valid instruction (incl. HALT) is latched into IF/ID; saturates at 16'hFFFF; not cleared by branch flush. Undefined: port and counter absent, all other behaviour identical.

Test Plan:
- Reset then start, memory 0:ADDI,1:SUBI,2:NOP -> if_pc 0,1,2 on consecutive cycles after start+1, if_valid=1, if_instr equals memory words.
- stall=1 for 3 cycles while if_pc=1 -> imem_addr stays 2, if_instr/if_pc unchanged, resume with if_pc=2.
- branch_taken=1, branch_target=8'h07 while pc=5 -> next cycle if_valid=0, if_instr=0; following cycle if_pc=7.
- HALT at addr 7 -> if_instr=16'h0800, if_valid=1, halted=1; thereafter if_valid=0, imem_addr=7 frozen for 10 cycles; start ignored.
- HALTED with branch_taken=1, target=8'h01 (same cycle as stall=1) -> halted=0, next fetch if_pc=1; pc=255 normal fetch -> next pc=0.
- rst_n=0 asserted mid-RUN between edges -> outputs at reset values immediately; with FETCH_CNT_EN fetch_cnt=0 and equals count of valid latches (e.g. 8 for addr 0..7 halt run).
